// File: rtl/cls_recovery_ctrl.sv
// cls_recovery_ctrl: fault-recovery sequencer for a triple-core lockstep cluster.
// A comparator fault accepted in RUN halts the cores, waits for them to go idle
// (or time out), holds them in reset, masks the comparator for a grace window and
// resumes. Repeated faults without an intervening clean window escalate to a sticky
// FATAL state that only software (fatal_clr) can leave.
// Optional build macro CLS_RECOVERY_LOG_EN adds a free-running cycle counter and a
// first-fault timestamp (first_fault_ts / log_valid).
module cls_recovery_ctrl #(
    parameter int RST_CYCLES   = 16,
    parameter int GRACE_CYCLES = 8,
    parameter int HALT_TIMEOUT = 64,
    parameter int MAX_RETRY    = 3,
    parameter int CLEAN_CYCLES = 1024,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmp_fault,
    input  logic             core_busy_ms,
    input  logic             core_busy_sl1,
    input  logic             core_busy_sl2,
    input  logic             fatal_clr,
    output logic             cores_halt,
    output logic             cores_rst,
    output logic             fault_mask,
    output logic             fault_irq,
    output logic             fatal,
    output logic [2:0]       state,
    output logic [3:0]       retry_cnt,
    output logic [CNT_W-1:0] fault_total
`ifdef CLS_RECOVERY_LOG_EN
    ,
    output logic [31:0]      first_fault_ts,
    output logic             log_valid
`endif
);

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_HALT  = 3'd1,
        ST_RESET = 3'd2,
        ST_GRACE = 3'd3,
        ST_FATAL = 3'd4
    } state_t;

    // One phase counter is shared by HALT, RESET and GRACE; size it for the longest.
    localparam int PH_MAX_A = (HALT_TIMEOUT > RST_CYCLES) ? HALT_TIMEOUT : RST_CYCLES;
    localparam int PH_MAX   = (PH_MAX_A > GRACE_CYCLES) ? PH_MAX_A : GRACE_CYCLES;
    localparam int PH_W     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int CL_W     = $clog2(CLEAN_CYCLES);

    localparam logic [PH_W-1:0] HALT_LAST  = PH_W'(HALT_TIMEOUT - 1);
    localparam logic [PH_W-1:0] RST_LAST   = PH_W'(RST_CYCLES - 1);
    localparam logic [PH_W-1:0] GRACE_LAST = PH_W'(GRACE_CYCLES - 1);
    localparam logic [CL_W-1:0] CLEAN_LAST = CL_W'(CLEAN_CYCLES - 1);
    localparam logic [3:0]      RETRY_MAX  = 4'(MAX_RETRY);

    state_t             state_reg, state_next;
    logic [PH_W-1:0]    phase_reg, phase_next;
    logic [CL_W-1:0]    clean_reg, clean_next;
    logic [3:0]         retry_reg, retry_next;
    logic [CNT_W-1:0]   total_reg, total_next;
    logic               irq_reg, irq_next;
    logic               fault_accept;
    logic               clr_accept;
    logic               busy_any;

    assign busy_any = core_busy_ms | core_busy_sl1 | core_busy_sl2;

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_RUN;
            phase_reg <= '0;
            clean_reg <= '0;
            retry_reg <= '0;
            total_reg <= '0;
            irq_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            phase_reg <= phase_next;
            clean_reg <= clean_next;
            retry_reg <= retry_next;
            total_reg <= total_next;
            irq_reg   <= irq_next;
        end
    end

    // Next-state, retry bookkeeping and clean-window tracking.
    always_comb begin
        state_next   = state_reg;
        clean_next   = '0;
        retry_next   = retry_reg;
        fault_accept = 1'b0;
        clr_accept   = 1'b0;
        phase_next   = '0;

        case (state_reg)
            ST_RUN: begin
                if (cmp_fault) begin
                    // A fault always beats a simultaneous clean-window expiry.
                    fault_accept = 1'b1;
                    if (retry_reg < RETRY_MAX) begin
                        retry_next = retry_reg + 4'd1;
                        state_next = ST_HALT;
                    end else begin
                        state_next = ST_FATAL;
                    end
                end else if (clean_reg == CLEAN_LAST) begin
                    retry_next = '0;
                end else begin
                    clean_next = clean_reg + CL_W'(1);
                end
            end
            ST_HALT: begin
                if (!busy_any || phase_reg == HALT_LAST) begin
                    state_next = ST_RESET;
                end
            end
            ST_RESET: begin
                if (phase_reg == RST_LAST) begin
                    state_next = ST_GRACE;
                end
            end
            ST_GRACE: begin
                if (phase_reg == GRACE_LAST) begin
                    state_next = ST_RUN;
                end
            end
            ST_FATAL: begin
                if (fatal_clr) begin
                    clr_accept = 1'b1;
                    retry_next = '0;
                    state_next = ST_RESET;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase

        // Phase counter restarts on every state change; it only matters in timed states.
        if (state_next == state_reg && state_reg != ST_RUN && state_reg != ST_FATAL) begin
            phase_next = phase_reg + PH_W'(1);
        end

        total_next = total_reg;
        if (fault_accept && total_reg != {CNT_W{1'b1}}) begin
            total_next = total_reg + CNT_W'(1);
        end
        irq_next = fault_accept;
    end

    // Control outputs decoded from the registered state only.
    always_comb begin
        cores_halt = 1'b0;
        cores_rst  = 1'b0;
        fault_mask = 1'b0;
        fatal      = 1'b0;
        case (state_reg)
            ST_HALT: begin
                cores_halt = 1'b1;
                fault_mask = 1'b1;
            end
            ST_RESET: begin
                cores_halt = 1'b1;
                cores_rst  = 1'b1;
                fault_mask = 1'b1;
            end
            ST_GRACE: begin
                fault_mask = 1'b1;
            end
            ST_FATAL: begin
                cores_halt = 1'b1;
                cores_rst  = 1'b1;
                fault_mask = 1'b1;
                fatal      = 1'b1;
            end
            default: begin
                cores_halt = 1'b0;
            end
        endcase
    end

    assign state       = state_reg;
    assign retry_cnt   = retry_reg;
    assign fault_total = total_reg;
    assign fault_irq   = irq_reg;

`ifdef CLS_RECOVERY_LOG_EN
    logic [31:0] cycle_cnt_reg;
    logic [31:0] ts_reg;
    logic        log_valid_reg;

    // Free-running timestamp and first-fault capture; re-armed by an accepted fatal_clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_reg <= '0;
            ts_reg        <= '0;
            log_valid_reg <= 1'b0;
        end else begin
            cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
            if (clr_accept) begin
                log_valid_reg <= 1'b0;
            end else if (fault_accept && !log_valid_reg) begin
                ts_reg        <= cycle_cnt_reg;
                log_valid_reg <= 1'b1;
            end
        end
    end

    assign first_fault_ts = ts_reg;
    assign log_valid      = log_valid_reg;
`endif

endmodule

// File: doc/cls_recovery_ctrl.md
Name: cls_recovery_ctrl

Overview:
- Fault-recovery sequencer for the triple-core lockstep cluster; consumes the lockstep comparator's fault flag and drives halt/reset of all three cores (ms, sl1, sl2).
- On each fault: halt cores, wait for quiescence, hold cores in reset, mask comparison during a grace window, resume.
- Counts retries; escalates to a sticky FATAL state when faults recur faster than a clean-run window clears them.

Parameters:
- RST_CYCLES, 16: cycles cores_rst held high per recovery (>=1).
- GRACE_CYCLES, 8: post-reset cycles during which cmp_fault is ignored (>=1).
- HALT_TIMEOUT, 64: maximum cycles in HALT waiting for all cores idle (>=1).
- MAX_RETRY, 3: recoveries allowed before FATAL (1..15).
- CLEAN_CYCLES, 1024: consecutive fault-free RUN cycles that clear retry_cnt (>=2).
- CNT_W, 8: width of the saturating lifetime fault counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- cmp_fault  in  1  fault level from lockstep comparator
- core_busy_ms  in  1  master core busy
- core_busy_sl1  in  1  slave 1 busy
- core_busy_sl2  in  1  slave 2 busy
- fatal_clr  in  1  software clear of FATAL; single-cycle pulse
- cores_halt  out  1  stall all three cores
- cores_rst  out  1  hold all three cores in reset
- fault_mask  out  1  comparator result ignored this cycle
- fault_irq  out  1  one-cycle pulse per accepted fault
- fatal  out  1  unrecoverable lockstep failure
- state  out  3  current FSM state encoding
- retry_cnt  out  4  recoveries since last clean window
- fault_total  out  CNT_W  lifetime accepted faults, saturating

Behaviour:
- All outputs are registered or decoded from registered state only.
- State encodings: RUN=0, HALT=1, RESET=2, GRACE=3, FATAL=4.
- Output decode per state:
  - RUN: all control outputs 0.
  - HALT: cores_halt=1, fault_mask=1.
  - RESET: cores_halt=1, cores_rst=1, fault_mask=1.
  - GRACE: fault_mask=1.
  - FATAL: cores_halt=1, cores_rst=1, fault_mask=1, fatal=1.
- On rst: state=RUN. All outputs, retry_cnt, fault_total and internal counters are 0. rst mid-sequence aborts immediately to RUN; the cores are reset by the same system reset.
- RUN, cmp_fault=1, retry_cnt<MAX_RETRY: go to HALT next cycle; retry_cnt+1; fault_total+1 (saturating at all-ones); fault_irq=1 for that one cycle.
- RUN, cmp_fault=1, retry_cnt==MAX_RETRY: go to FATAL instead; fault_total+1, fault_irq pulse, retry_cnt unchanged.
- Clean counter:
  - Increments in each fault-free RUN cycle.
  - Reaching CLEAN_CYCLES-1 clears retry_cnt and the clean counter.
  - Reset to 0 on any accepted fault and on leaving RUN.
  - If the fault and clean expiry fall in the same cycle, the fault wins: no clear, and the increment uses the current retry_cnt.
- HALT: go to RESET when all three busy inputs are 0 (the first such cycle counts), or when the timeout counter reaches HALT_TIMEOUT-1, whichever comes first.
- RESET: stay exactly RST_CYCLES cycles, then go to GRACE.
- GRACE: stay exactly GRACE_CYCLES cycles, then go to RUN.
- cmp_fault is ignored in all states other than RUN. No irq and no counting outside RUN.
- FATAL: sticky. fatal_clr=1 clears retry_cnt and goes to RESET; the normal RESET→GRACE→RUN sequence follows. fatal_clr in any other state is ignored.
- A held cmp_fault level re-evaluated on the first RUN cycle after GRACE counts as a new fault.

Optional Feature:
- Macro: CLS_RECOVERY_LOG_EN.
- When defined:
  - Adds a free-running 32-bit cycle counter, cleared by rst and wrapping at 2^32.
  - Adds output first_fault_ts (32 bits) and output log_valid (1 bit).
  - On the first accepted fault after rst or after fatal_clr, first_fault_ts latches the counter value and log_valid goes to 1.
  - Later faults do not overwrite first_fault_ts.
  - fatal_clr clears log_valid.
- When not defined: those ports and the counter are absent, and all other behaviour is identical.

Test Plan:
- Recovery sequence, defaults, busy all 0, 1-cycle cmp_fault at cycle T:
  - fault_irq=1 at T+1 only, state=HALT at T+1.
  - cores_rst=1 for T+2..T+17.
  - fault_mask=1 for T+1..T+25.
  - state=RUN at T+26; retry_cnt=1, fault_total=1.
- HALT timeout: core_busy_sl1 stuck at 1, fault → state=HALT for exactly 64 cycles, then RESET.
- Escalation: 4 faults each injected on the first RUN cycle after recovery → retry_cnt reaches 3; 4th fault gives state=FATAL, fatal=1, cores_rst=1, fault_total=4. fatal_clr pulse → RESET, retry_cnt=0, RUN after 24 more cycles.
- Decay and masking:
  - One fault, then 1024 clean RUN cycles → retry_cnt back to 0.
  - cmp_fault pulsed during GRACE → no irq, fault_total unchanged.
- Saturation and reset: with CNT_W=2, 5 recovered faults → fault_total=3. rst asserted mid-RESET → next cycle state=0 with all outputs 0.
- With CLS_RECOVERY_LOG_EN: free-running counter = 100 in the cycle the first fault is accepted → first_fault_ts=100, log_valid=1; a second fault leaves first_fault_ts unchanged.
